// File: rtl/pipo_arb_pkg.sv
// Shared types and helpers for the PIPO load arbiter.
// The optional ARB_LOCK_EN build adds a per-requester LOCK input on the top level.
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the first set request at or after the pointer, wrapping mod N.
module rr_priority_pick
  import pipo_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = idx_w(DEF_N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_pointer,
  output logic [IW-1:0] o_winner,
  output logic          o_any_req
);

  int w_best;

  // The winner is the set request with the smallest forward distance from the pointer.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    w_best    = N;
    for (int j = 0; j < N; j++) begin
      if (i_req[j] && (((j + N - int'(i_pointer)) % N) < w_best)) begin
        w_best    = (j + N - int'(i_pointer)) % N;
        o_winner  = IW'(j);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that sequences single-cycle loads into a shared PIPO register.
// Defining ARB_LOCK_EN adds a LOCK input that pins arbitration to the last granted requester.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int W           = DEF_W,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [N-1:0]          REQ,
  input  logic [N*W-1:0]        REQ_DATA,
  output logic [N-1:0]          GNT,
  output logic                  LOAD,
  output logic [W-1:0]          DATA_OUT,
  input  logic [W-1:0]          REG_Q,
  output logic [idx_w(N)-1:0]   OWNER,
  output logic                  VALID,
  output logic                  BUSY,
  output logic [W-1:0]          RDATA,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]          LOCK,
`endif
  output arb_state_t            DBG_STATE
);

  localparam int IW = idx_w(N);
  localparam logic [3:0]    HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  arb_state_t    r_state;
  arb_state_t    w_next_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_winner;
  logic [W-1:0]  r_data;
  logic [IW-1:0] r_owner;
  logic          r_valid;
  logic [3:0]    r_hold_cnt;

  logic [N-1:0]  w_req_eff;
  logic [IW-1:0] w_ptr_eff;
  logic [IW-1:0] w_winner;
  logic          w_any;
  logic [W-1:0]  w_sel_data;

`ifdef ARB_LOCK_EN
  logic          r_lock;
  logic [N-1:0]  w_owner_oh;
  logic          w_lock_hold;
  logic          w_lock_release;

  always_comb begin
    w_owner_oh = '0;
    for (int j = 0; j < N; j++) w_owner_oh[j] = (r_owner == IW'(j));
  end

  // A held lock masks every other requester; dropping it resumes rotation past the owner.
  assign w_lock_hold    = r_lock && |(LOCK & w_owner_oh);
  assign w_lock_release = r_lock && !(|(LOCK & w_owner_oh)) && (r_state == ST_IDLE);
  assign w_req_eff      = w_lock_hold ? (REQ & w_owner_oh) : REQ;
  assign w_ptr_eff      = w_lock_release ? rr_next(r_owner) : r_ptr;
`else
  assign w_req_eff = REQ;
  assign w_ptr_eff = r_ptr;
`endif

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req     (w_req_eff),
    .i_pointer (w_ptr_eff),
    .o_winner  (w_winner),
    .o_any_req (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < N; j++) begin
      if (w_winner == IW'(j)) w_sel_data = REQ_DATA[j*W +: W];
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next_state = ST_LOAD;
      ST_LOAD: w_next_state = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (r_hold_cnt == 4'd0) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_winner   <= '0;
      r_data     <= '0;
      r_owner    <= '0;
      r_valid    <= 1'b0;
      r_hold_cnt <= 4'd0;
`ifdef ARB_LOCK_EN
      r_lock     <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner <= w_winner;
            r_data   <= w_sel_data;
          end
`ifdef ARB_LOCK_EN
          if (w_lock_release) begin
            r_lock <= 1'b0;
            r_ptr  <= rr_next(r_owner);
          end
`endif
        end
        ST_LOAD: begin
          r_owner    <= r_winner;
          r_valid    <= 1'b1;
          r_hold_cnt <= HOLD_INIT;
`ifdef ARB_LOCK_EN
          if (|(LOCK & GNT)) begin
            r_lock <= 1'b1;
          end else begin
            r_lock <= 1'b0;
            r_ptr  <= rr_next(r_winner);
          end
`else
          r_ptr <= rr_next(r_winner);
`endif
        end
        ST_HOLD: if (r_hold_cnt != 4'd0) r_hold_cnt <= r_hold_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  assign LOAD = (r_state == ST_LOAD);
  assign BUSY = (r_state != ST_IDLE);

  always_comb begin
    GNT = '0;
    for (int j = 0; j < N; j++) GNT[j] = LOAD && (r_winner == IW'(j));
  end

  assign DATA_OUT  = r_data;
  assign OWNER     = r_owner;
  assign VALID     = r_valid;
  assign RDATA     = r_valid ? REG_Q : '0;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: directed vectors, multi-cycle corner cases and a randomized
// run against a cycle-level reference model, with a bench-side PIPO register on each DUT.
module tb_pipo_load_arbiter;
  import pipo_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int HM = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   req        = '0;
  logic [N*W-1:0] req_data   = '0;
  logic [N-1:0]   req_h      = '0;
  logic [N*W-1:0] req_data_h = '0;
  logic [N-1:0]   lock       = '0;

  logic [N-1:0] gnt, gnt_h;
  logic         load, load_h, valid, valid_h, busy, busy_h;
  logic [W-1:0] dout, dout_h, rdata, rdata_h;
  logic [1:0]   owner, owner_h;
  arb_state_t   st, st_h;
  logic [W-1:0] reg_q   = '0;
  logic [W-1:0] reg_q_h = '0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
  } vec_t;
  vec_t tbl[6];

  // Reference model state.
  int           m_ptr, m_owner, m_load_w, m_hold;
  logic         m_valid;
  logic [W-1:0] m_reg, m_dout, m_load_d;

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (load) reg_q <= dout;
  always_ff @(posedge clk) if (load_h) reg_q_h <= dout_h;

  pipo_load_arbiter #(.N(N), .W(W), .HOLD_CYCLES(HM)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .REQ_DATA(req_data), .GNT(gnt), .LOAD(load),
    .DATA_OUT(dout), .REG_Q(reg_q), .OWNER(owner), .VALID(valid), .BUSY(busy),
    .RDATA(rdata),
`ifdef ARB_LOCK_EN
    .LOCK(lock),
`endif
    .DBG_STATE(st)
  );

  pipo_load_arbiter #(.N(N), .W(W), .HOLD_CYCLES(3)) dut_h (
    .CLK(clk), .RST_N(rst_n), .REQ(req_h), .REQ_DATA(req_data_h), .GNT(gnt_h),
    .LOAD(load_h), .DATA_OUT(dout_h), .REG_Q(reg_q_h), .OWNER(owner_h), .VALID(valid_h),
    .BUSY(busy_h), .RDATA(rdata_h),
`ifdef ARB_LOCK_EN
    .LOCK(lock),
`endif
    .DBG_STATE(st_h)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance the model by one clock edge, given the inputs that edge will sample.
  task automatic model_step();
    if (m_load_w >= 0) begin
      m_reg    = m_load_d;
      m_owner  = m_load_w;
      m_valid  = 1'b1;
      m_ptr    = (m_load_w + 1) % N;
      m_load_w = -1;
      m_hold   = HM;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      for (int d = 0; d < N; d++) begin
        int idx;
        idx = (m_ptr + d) % N;
        if (m_load_w < 0 && req[idx[1:0]]) begin
          m_load_w = idx;
          m_load_d = W'(req_data >> (idx * W));
          m_dout   = m_load_d;
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{req: 4'b0010, data: 16'h00A0, gnt: 4'b0010, q: 4'hA, owner: 2'd1};
    tbl[1] = '{req: 4'b1001, data: 16'h9ABC, gnt: 4'b1000, q: 4'h9, owner: 2'd3};
    tbl[2] = '{req: 4'b1001, data: 16'h9ABC, gnt: 4'b0001, q: 4'hC, owner: 2'd0};
    tbl[3] = '{req: 4'b0110, data: 16'h1234, gnt: 4'b0010, q: 4'h3, owner: 2'd1};
    tbl[4] = '{req: 4'b0011, data: 16'h5678, gnt: 4'b0001, q: 4'h8, owner: 2'd0};
    tbl[5] = '{req: 4'b1000, data: 16'hE000, gnt: 4'b1000, q: 4'hE, owner: 2'd3};

    // Reset values while reset is asserted.
    @(negedge clk);
    #1;
    chk("rst_load",  32'(load),  32'd0);
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    do_reset();

    // Directed vectors; later entries depend on the rotation left by earlier ones.
    for (int i = 0; i < 6; i++) begin
      req      = tbl[i].req;
      req_data = tbl[i].data;
      @(negedge clk);
      chk("vec_load", 32'(load), 32'd1);
      chk("vec_gnt",  32'(gnt),  32'(tbl[i].gnt));
      req      = '0;
      req_data = 16'(($urandom));
      @(negedge clk);
      chk("vec_load_off", 32'(load),  32'd0);
      chk("vec_regq",     32'(reg_q), 32'(tbl[i].q));
      chk("vec_owner",    32'(owner), 32'(tbl[i].owner));
      chk("vec_valid",    32'(valid), 32'd1);
      chk("vec_rdata",    32'(rdata), 32'(tbl[i].q));
    end

    // All-request rotation from a fresh pointer.
    do_reset();
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    req      = 4'hF;
    req_data = 16'h4321;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rot_load", 32'(load), 32'd1);
        chk("rot_gnt",  32'(gnt),  32'(1 << ((k / 2) % 4)));
      end else begin
        chk("rot_load_off", 32'(load), 32'd0);
        chk("rot_regq", 32'(reg_q), 32'(exp_q.pop_front()));
      end
      if (k == 9) req = '0;
    end

    // Withdrawal after latching still completes the write with the latched data.
    req      = 4'b0100;
    req_data = 16'h0700;
    @(negedge clk);
    chk("wd_gnt", 32'(gnt), 32'b0100);
    req      = '0;
    req_data = 16'h0300;
    @(negedge clk);
    chk("wd_regq",  32'(reg_q), 32'h7);
    chk("wd_owner", 32'(owner), 32'd2);

    // Reset asserted in the middle of a LOAD cycle.
    req      = 4'b0010;
    req_data = 16'h00B0;
    @(negedge clk);
    chk("rml_load", 32'(load), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rml_load_drop", 32'(load),  32'd0);
    chk("rml_gnt_drop",  32'(gnt),   32'd0);
    chk("rml_valid",     32'(valid), 32'd0);
    chk("rml_rdata",     32'(rdata), 32'd0);
    @(posedge clk);
    #1;
    chk("rml_regq_kept", 32'(reg_q), 32'h7);
    @(negedge clk);
    req      = 4'hF;
    req_data = 16'h4321;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rml_first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    @(negedge clk);
    chk("rml_regq_new", 32'(reg_q), 32'h1);

    // Hold window of three cycles on the second instance.
    req_h      = 4'b0001;
    req_data_h = 16'h000D;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("hold_load", 32'(load_h), 32'(k % 5 == 0));
      chk("hold_busy", 32'(busy_h), 32'(k % 5 != 4));
      if (k == 1) chk("hold_regq", 32'(reg_q_h), 32'hD);
    end
    req_h = '0;

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_owner = 0; m_load_w = -1; m_hold = 0;
    m_valid = 1'b0; m_dout = '0; m_reg = reg_q; m_load_d = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      req      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      req_data = 16'($urandom);
      model_step();
      @(negedge clk);
      chk("rnd_load",  32'(load),  32'(m_load_w >= 0));
      chk("rnd_gnt",   32'(gnt),   (m_load_w >= 0) ? 32'(1 << m_load_w) : 32'd0);
      chk("rnd_busy",  32'(busy),  32'((m_load_w >= 0) || (m_hold > 0)));
      chk("rnd_owner", 32'(owner), 32'(m_owner));
      chk("rnd_valid", 32'(valid), 32'(m_valid));
      chk("rnd_dout",  32'(dout),  32'(m_dout));
      chk("rnd_regq",  32'(reg_q), 32'(m_reg));
      chk("rnd_rdata", 32'(rdata), m_valid ? 32'(m_reg) : 32'd0);
    end
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
